// File: rtl/z88_video_pkg.sv
// Shared VRAM geometry and default VGA timing for the Z88 video path.
// VRAM_SCAN_LINEDBL_EN selects the line-doubled 128-row window (WIN_Y0 176).
package z88_video_pkg;
   localparam int VRAM_AW   = 14;
   localparam int LINE_W    = 6;
   localparam int NIB_W     = 8;
   localparam int Z88_LINES = 64;
   localparam int NIB_PIX   = 4;
   localparam int CNT_W     = 10;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_SYNC_S = 656;
   localparam int VGA_H_SYNC_E = 752;
   localparam int VGA_H_TOTAL  = 800;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_SYNC_S = 490;
   localparam int VGA_V_SYNC_E = 492;
   localparam int VGA_V_TOTAL  = 525;

`ifdef VRAM_SCAN_LINEDBL_EN
   localparam int LINE_SHIFT = 1;
   localparam int WIN_Y0_DEF = 176;
`else
   localparam int LINE_SHIFT = 0;
   localparam int WIN_Y0_DEF = 208;
`endif
   localparam int WIN_ROWS = Z88_LINES << LINE_SHIFT;

   typedef logic [CNT_W-1:0] cnt_t;

   typedef struct packed {
      logic hs;
      logic vs;
      logic de;
      logic frame;
   } sync_t;

   localparam sync_t SYNC_RST = '{hs: 1'b1, vs: 1'b1, de: 1'b0, frame: 1'b0};

   function automatic logic in_span(input cnt_t x, input cnt_t lo, input cnt_t hi);
      return (x >= lo) && (x < hi);
   endfunction
endpackage

// File: rtl/vram_scan_timing.sv
// Raster position counters, next-pixel lookahead and registered hs/vs/de/frame decode.
module vram_scan_timing
   import z88_video_pkg::*;
#(
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_SYNC_S = VGA_H_SYNC_S,
   parameter int H_SYNC_E = VGA_H_SYNC_E,
   parameter int H_TOTAL  = VGA_H_TOTAL,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_SYNC_S = VGA_V_SYNC_S,
   parameter int V_SYNC_E = VGA_V_SYNC_E,
   parameter int V_TOTAL  = VGA_V_TOTAL
)(
   input  logic             mck,
   input  logic             rin,
   input  logic             pce,
   output logic [1:0]       hphase,
   output logic [CNT_W-1:0] vcnt,
   output logic [CNT_W-1:0] hnext,
   output logic [CNT_W-1:0] vnext,
   output logic             active,
   output logic             hs,
   output logic             vs,
   output logic             de,
   output logic             frame
);
   localparam cnt_t ZERO_C    = cnt_t'(0);
   localparam cnt_t ONE_C     = cnt_t'(1);
   localparam cnt_t HA_C      = cnt_t'(H_ACTIVE);
   localparam cnt_t HSS_C     = cnt_t'(H_SYNC_S);
   localparam cnt_t HSE_C     = cnt_t'(H_SYNC_E);
   localparam cnt_t HT_LAST_C = cnt_t'(H_TOTAL - 1);
   localparam cnt_t VA_C      = cnt_t'(V_ACTIVE);
   localparam cnt_t VSS_C     = cnt_t'(V_SYNC_S);
   localparam cnt_t VSE_C     = cnt_t'(V_SYNC_E);
   localparam cnt_t VT_LAST_C = cnt_t'(V_TOTAL - 1);

   cnt_t  hcnt_r;
   cnt_t  vcnt_r;
   cnt_t  hnext_s;
   cnt_t  vnext_s;
   sync_t sync_s;
   sync_t sync_r;

   // Position of the pixel after the current one, wrapping row and frame
   always_comb begin
      if (hcnt_r == HT_LAST_C) begin
         hnext_s = ZERO_C;
         if (vcnt_r == VT_LAST_C) begin
            vnext_s = ZERO_C;
         end else begin
            vnext_s = vcnt_r + ONE_C;
         end
      end else begin
         hnext_s = hcnt_r + ONE_C;
         vnext_s = vcnt_r;
      end
   end

   // Raster counters advance only on pixel ticks
   always_ff @(posedge mck) begin
      if (rin) begin
         hcnt_r <= ZERO_C;
         vcnt_r <= ZERO_C;
      end else if (pce) begin
         hcnt_r <= hnext_s;
         vcnt_r <= vnext_s;
      end
   end

   // Sync and enable decode for the pixel being evaluated this tick
   always_comb begin
      sync_s.de    = (hcnt_r < HA_C) && (vcnt_r < VA_C);
      sync_s.hs    = !in_span(hcnt_r, HSS_C, HSE_C);
      sync_s.vs    = !in_span(vcnt_r, VSS_C, VSE_C);
      sync_s.frame = (vcnt_r == VA_C) && (hcnt_r == ZERO_C);
   end

   // Registered sync outputs, aligned with the pixel register in the top
   always_ff @(posedge mck) begin
      if (rin) begin
         sync_r <= SYNC_RST;
      end else if (pce) begin
         sync_r <= sync_s;
      end
   end

   assign hphase = hcnt_r[1:0];
   assign vcnt   = vcnt_r;
   assign hnext  = hnext_s;
   assign vnext  = vnext_s;
   assign active = sync_s.de;
   assign hs     = sync_r.hs;
   assign vs     = sync_r.vs;
   assign de     = sync_r.de;
   assign frame  = sync_r.frame;
endmodule

// File: rtl/vram_scan.sv
// Scans the Z88 nibble frame buffer into a VGA raster: fetch one pixel ahead, serialise MSB-first.
// VRAM_SCAN_LINEDBL_EN (see z88_video_pkg) shows each Z88 line on two display rows.
module vram_scan
   import z88_video_pkg::*;
#(
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_SYNC_S = VGA_H_SYNC_S,
   parameter int H_SYNC_E = VGA_H_SYNC_E,
   parameter int H_TOTAL  = VGA_H_TOTAL,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_SYNC_S = VGA_V_SYNC_S,
   parameter int V_SYNC_E = VGA_V_SYNC_E,
   parameter int V_TOTAL  = VGA_V_TOTAL,
   parameter int WIN_Y0   = WIN_Y0_DEF
)(
   input  logic               mck,
   input  logic               rin,
   input  logic               pce,
   input  logic               lcdon,
   output logic [VRAM_AW-1:0] vram_ra,
   input  logic [NIB_PIX-1:0] vram_rd,
   output logic               pix,
   output logic               hs,
   output logic               vs,
   output logic               de,
   output logic               frame
);
   localparam cnt_t WY0_C = cnt_t'(WIN_Y0);
   localparam cnt_t WY1_C = cnt_t'(WIN_Y0 + WIN_ROWS);
   localparam cnt_t HA_C  = cnt_t'(H_ACTIVE);

   logic [1:0]         hphase_s;
   cnt_t               vcnt_s;
   cnt_t               hnext_s;
   cnt_t               vnext_s;
   logic               active_s;
   logic               win_cur_s;
   logic               win_nxt_s;
   logic               fetch_s;
   logic [LINE_W-1:0]  line_nxt_s;
   logic [VRAM_AW-1:0] ra_r;
   logic [NIB_PIX-2:0] shift_r;
   logic [NIB_PIX-2:0] shift_nx_s;
   logic               cand_s;
   logic               pix_nx_s;
   logic               pix_r;

   vram_scan_timing #(
      .H_ACTIVE (H_ACTIVE),
      .H_SYNC_S (H_SYNC_S),
      .H_SYNC_E (H_SYNC_E),
      .H_TOTAL  (H_TOTAL),
      .V_ACTIVE (V_ACTIVE),
      .V_SYNC_S (V_SYNC_S),
      .V_SYNC_E (V_SYNC_E),
      .V_TOTAL  (V_TOTAL)
   ) u_timing (
      .mck    (mck),
      .rin    (rin),
      .pce    (pce),
      .hphase (hphase_s),
      .vcnt   (vcnt_s),
      .hnext  (hnext_s),
      .vnext  (vnext_s),
      .active (active_s),
      .hs     (hs),
      .vs     (vs),
      .de     (de),
      .frame  (frame)
   );

   // Window membership and fetch decision for the upcoming pixel
   always_comb begin
      win_cur_s  = in_span(vcnt_s, WY0_C, WY1_C);
      win_nxt_s  = in_span(vnext_s, WY0_C, WY1_C);
      line_nxt_s = LINE_W'((vnext_s - WY0_C) >> LINE_SHIFT);
      fetch_s    = win_nxt_s && (hnext_s[1:0] == 2'b00) && (hnext_s < HA_C);
   end

   // VRAM address register; the data comes back before the next pixel tick
   always_ff @(posedge mck) begin
      if (rin) begin
         ra_r <= {VRAM_AW{1'b0}};
      end else if (pce && fetch_s) begin
         ra_r <= {line_nxt_s, hnext_s[NIB_W+1:2]};
      end
   end

   // Serialiser: bit3 goes out on the nibble's first pixel, the rest shift out after it
   always_comb begin
      if (hphase_s == 2'b00) begin
         cand_s     = vram_rd[NIB_PIX-1];
         shift_nx_s = vram_rd[NIB_PIX-2:0];
      end else begin
         cand_s     = shift_r[NIB_PIX-2];
         shift_nx_s = {shift_r[NIB_PIX-3:0], 1'b0};
      end
      pix_nx_s = cand_s && active_s && win_cur_s && lcdon;
   end

   // Pixel and shift registers
   always_ff @(posedge mck) begin
      if (rin) begin
         shift_r <= {(NIB_PIX-1){1'b0}};
         pix_r   <= 1'b0;
      end else if (pce) begin
         shift_r <= shift_nx_s;
         pix_r   <= pix_nx_s;
      end
   end

   assign vram_ra = ra_r;
   assign pix     = pix_r;
endmodule

// File: tb/tb_vram_scan.sv
// Self-checking bench for vram_scan on a reduced raster, against a position-based reference model.
module tb_vram_scan;
   localparam int HA  = 48;
   localparam int HSS = 56;
   localparam int HSE = 64;
   localparam int HT  = 80;
   localparam int VA  = 160;
   localparam int VSS = 164;
   localparam int VSE = 166;
   localparam int VT  = 170;
   localparam int WY  = 16;
`ifdef VRAM_SCAN_LINEDBL_EN
   localparam int WH  = 128;
   localparam int LDIV = 2;
`else
   localparam int WH  = 64;
   localparam int LDIV = 1;
`endif
   localparam int FRAME = HT * VT;

   logic        mck = 1'b0;
   logic        rin = 1'b1;
   logic        pce = 1'b0;
   logic        lcdon = 1'b0;
   logic [13:0] vram_ra;
   logic [3:0]  vram_rd;
   logic        pix, hs, vs, de, frame;
   logic [3:0]  mem [0:16383];

   int          checks = 0;
   int          errors = 0;
   int          pos = 0;
   logic [13:0] exp_ra = 14'd0;
   bit          directed_on = 1'b0;
   logic [3:0]  first_nib = 4'b1010;

   assign vram_rd = mem[vram_ra];

   always #5 mck = ~mck;

   vram_scan #(
      .H_ACTIVE (HA), .H_SYNC_S (HSS), .H_SYNC_E (HSE), .H_TOTAL (HT),
      .V_ACTIVE (VA), .V_SYNC_S (VSS), .V_SYNC_E (VSE), .V_TOTAL (VT),
      .WIN_Y0   (WY)
   ) dut (
      .mck     (mck),
      .rin     (rin),
      .pce     (pce),
      .lcdon   (lcdon),
      .vram_ra (vram_ra),
      .vram_rd (vram_rd),
      .pix     (pix),
      .hs      (hs),
      .vs      (vs),
      .de      (de),
      .frame   (frame)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s pos=%0d observed=%0h expected=%0h", tag, pos, obs, expv);
      end
   endtask

   function automatic bit in_win(input int v);
      return (v >= WY) && (v < WY + WH);
   endfunction

   function automatic int line_of(input int v);
      return (v - WY) / LDIV;
   endfunction

   task automatic step(input logic pe);
      pce = pe;
      @(posedge mck);
      #1;
   endtask

   task automatic check_reset();
      chk("rst_pix", 32'(pix), 32'd0);
      chk("rst_hs", 32'(hs), 32'd1);
      chk("rst_vs", 32'(vs), 32'd1);
      chk("rst_de", 32'(de), 32'd0);
      chk("rst_frame", 32'(frame), 32'd0);
      chk("rst_ra", 32'(vram_ra), 32'd0);
   endtask

   // Compare outputs after the tick that evaluated raster position 'pos'
   task automatic check_tick();
      int h, v, nh, nv;
      bit e_de, e_pix;
      logic [3:0] nib;
      h = pos % HT;
      v = (pos / HT) % VT;
      e_de = (h < HA) && (v < VA);
      e_pix = 1'b0;
      if (e_de && in_win(v) && lcdon) begin
         nib = mem[line_of(v) * 256 + h / 4];
         e_pix = nib[3 - (h % 4)];
      end
      chk("de", 32'(de), 32'(e_de));
      chk("hs", 32'(hs), 32'(!((h >= HSS) && (h < HSE))));
      chk("vs", 32'(vs), 32'(!((v >= VSS) && (v < VSE))));
      chk("frame", 32'(frame), 32'((v == VA) && (h == 0)));
      chk("pix", 32'(pix), 32'(e_pix));
      if (directed_on && v == WY && h < 4)
         chk("first_nib", 32'(pix), 32'(first_nib[3 - (h % 4)]));
      if (directed_on && v == WY + WH - 1 && h >= HA - 4 && h < HA)
         chk("last_nib", 32'(pix), 32'd1);
      if (directed_on && (v == WY - 1 || v == WY + WH) && h < HA)
         chk("edge_row_dark", 32'({de, pix}), 32'(2'b10));
      nh = (pos + 1) % HT;
      nv = ((pos + 1) / HT) % VT;
      if ((nh % 4 == 0) && (nh < HA) && in_win(nv))
         exp_ra = 14'(line_of(nv) * 256 + nh / 4);
      chk("vram_ra", 32'(vram_ra), 32'(exp_ra));
      pos++;
   endtask

   // n pixel ticks, each preceded by gap-1 idle mck cycles during which outputs must hold
   task automatic run_ticks(input int n, input int gap);
      logic [18:0] held;
      for (int i = 0; i < n; i++) begin
         for (int g = 1; g < gap; g++) begin
            held = {pix, hs, vs, de, frame, vram_ra};
            step(1'b0);
            chk("hold", 32'({pix, hs, vs, de, frame, vram_ra}), 32'(held));
         end
         step(1'b1);
         check_tick();
      end
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) mem[i] = 4'($urandom);
      mem[0] = 4'b1010;
      mem[63 * 256 + HA / 4 - 1] = 4'hF;

      // Reset with pce high, then free-running pixel clock over a full frame
      rin = 1'b1;
      step(1'b1);
      step(1'b1);
      check_reset();
      rin = 1'b0;
      lcdon = 1'b1;
      directed_on = 1'b1;
      pos = 0;
      exp_ra = 14'd0;
      run_ticks(FRAME + 2 * HT, 1);

      // Pixel clock every third mck
      run_ticks(7000, 3);

      // Display disabled over bright VRAM, then re-enabled mid-row
      directed_on = 1'b0;
      lcdon = 1'b0;
      for (int i = 0; i < 16384; i++) mem[i] = 4'hF;
      run_ticks(6500, 1);
      lcdon = 1'b1;
      for (int i = 0; i < FRAME && (pos % FRAME) != (40 * HT + 20); i++)
         run_ticks(1, 1);
      chk("reach_mid", 32'(pos % FRAME), 32'(40 * HT + 20));

      // Reset mid-frame with pce low: reset wins
      rin = 1'b1;
      step(1'b0);
      check_reset();
      rin = 1'b0;
      pos = 0;
      exp_ra = 14'd0;
      step(1'b1);
      chk("post_rst_de", 32'(de), 32'd1);
      check_tick();
      run_ticks(300, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
